// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and data width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_ctrl_piso.sv
// Tx_PISO: parallel-in/serial-out shift register, LSB first, zero-filling on shift.
module Tx_PISO
    import uart_pkg::*;
(
    input  logic                      clk,
    input  logic                      piso_reset,
    input  logic                      Load_data,
    input  logic                      shift,
    input  logic [UART_DATA_BITS-1:0] Data_in,
    output logic                      Data_out
);

    logic [UART_DATA_BITS-1:0] sreg_q;
    logic [UART_DATA_BITS-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (Load_data) begin
            sreg_d = Data_in;
        end else if (shift) begin
            sreg_d = {1'b0, sreg_q[UART_DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge piso_reset) begin
        if (!piso_reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign Data_out = sreg_q[0];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: baud timing, frame FSM and strobes for Tx_PISO.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      tx_reset,
    input  logic                      tx_start,
    input  logic [UART_DATA_BITS-1:0] tx_data_in,
    output logic                      tx_out,
    output logic                      tx_busy,
    output logic                      tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TC_VAL = CW'(CLKS_PER_BIT - 1);

    uart_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tc;
    logic          load;
    logic          shift;
    logic          piso_out;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    Tx_PISO u_piso (
        .clk        (clk),
        .piso_reset (tx_reset),
        .Load_data  (load),
        .shift      (shift),
        .Data_in    (tx_data_in),
        .Data_out   (piso_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        load    = 1'b0;
        shift   = 1'b0;
        tc      = (cnt_q == TC_VAL);
        if (state_q != IDLE) begin
            cnt_d = tc ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    load    = 1'b1;
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (tc) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tc) begin
                    shift = 1'b1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tc) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so decode them from the upcoming state/count.
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == TC_VAL);
    end

`ifdef UART_TX_PARITY_EN
    assign parity_d = load ? ^tx_data_in : parity_q;
`endif

    always_ff @(posedge clk or negedge tx_reset) begin
        if (!tx_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        case (state_q)
            IDLE:    tx_out = 1'b1;
            START:   tx_out = 1'b0;
            DATA:    tx_out = piso_out;
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out = parity_q;
`endif
            STOP:    tx_out = 1'b1;
            default: tx_out = 1'b1;
        endcase
    end

    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT = 4; adapts to UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       tx_reset;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .tx_reset   (tx_reset),
        .tx_start   (tx_start),
        .tx_data_in (tx_data_in),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Frame bits in line order: start, d[0..7], then parity (if enabled) and stop.
    function automatic logic [10:0] fr(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, p, d, 1'b0};
`else
        fr = {p, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_out%0d", tag, i), tx_out, 1'b1);
            chk($sformatf("%s_busy%0d", tag, i), tx_busy, 1'b0);
            chk($sformatf("%s_done%0d", tag, i), tx_done, 1'b0);
        end
    endtask

    // Called away from posedge with DUT idle; request is accepted at the next posedge.
    task automatic send(input string tag, input logic [7:0] d, input logic p,
                        input bit hold, input bit mid_pulse);
        logic [10:0] exp;
        exp = fr(d, p);
        tx_start   = 1'b1;
        tx_data_in = d;
        @(posedge clk);
        #1;
        if (!hold) tx_start = 1'b0;
        for (int k = 1; k <= NB * CPB; k++) begin
            @(negedge clk);
            chk($sformatf("%s_out_c%0d", tag, k), tx_out, exp[(k - 1) / CPB]);
            chk($sformatf("%s_busy_c%0d", tag, k), tx_busy, 1'b1);
            chk($sformatf("%s_done_c%0d", tag, k), tx_done, (k == NB * CPB));
            if (mid_pulse && k == 12) begin
                tx_start   = 1'b1;
                tx_data_in = 8'hFF;
            end
            if (mid_pulse && k == 13) begin
                tx_start   = 1'b0;
                tx_data_in = 8'h00;
            end
        end
        @(negedge clk);
        chk({tag, "_gap_out"}, tx_out, 1'b1);
        chk({tag, "_gap_busy"}, tx_busy, 1'b0);
        chk({tag, "_gap_done"}, tx_done, 1'b0);
    endtask

    initial begin
        tx_reset   = 1'b0;
        tx_start   = 1'b0;
        tx_data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_out", tx_out, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        tx_reset = 1'b1;

        idle_check("idle", 20);

        // Parity: A5 has four ones -> 0; 07 has three -> 1.
        send("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        send("07", 8'h07, 1'b1, 1'b0, 1'b0);
        send("a5b", 8'hA5, 1'b0, 1'b0, 1'b0);

        send("busy00", 8'h00, 1'b0, 1'b0, 1'b1);
        idle_check("noreq", 8);

        send("hold1", 8'h3C, 1'b0, 1'b1, 1'b0);
        send("hold2", 8'h3C, 1'b0, 1'b1, 1'b0);
        tx_start = 1'b0;
        idle_check("holdend", 6);

        // Cycles 17..20 after acceptance carry data bit 3 (A5 bit 3 = 0).
        tx_start   = 1'b1;
        tx_data_in = 8'hA5;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_rst_out", tx_out, 1'b0);
        chk("pre_rst_busy", tx_busy, 1'b1);
        tx_reset = 1'b0;
        #1;
        chk("midrst_out", tx_out, 1'b1);
        chk("midrst_busy", tx_busy, 1'b0);
        chk("midrst_done", tx_done, 1'b0);
        repeat (3) @(negedge clk);
        tx_reset = 1'b1;
        idle_check("postrst", 2);
        send("55", 8'h55, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences the 8-bit parallel-in/serial-out shift register into a complete asynchronous serial frame. The frame is start bit, 8 data bits LSB first, optional parity bit, and stop bit. It owns the baud-rate timing, the frame state machine and the load/shift strobes to the shift register. It sits between the host-side byte interface and the serial line pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit time. Legal range ≥ 2; 868 gives 115200 baud at 100 MHz.
- `clk` input 1: single clock; all state changes on its rising edge.
- `tx_reset` input 1: reset, asynchronous and active-low.
- `tx_start` input 1: request to send `tx_data_in`. Honoured only while `tx_busy` = 0.
- `tx_data_in` input 8: byte to transmit. Sampled only in the cycle `tx_start` is accepted.
- `tx_out` output 1: serial line. Idles high.
- `tx_busy` output 1: high from the cycle after acceptance through the last stop-bit cycle.
- `tx_done` output 1: single-cycle pulse in the last cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (only when compiled in), STOP.
- IDLE:
  - `tx_out` = 1.
  - `tx_start` = 1 asserts the shift-register load strobe combinationally in the same cycle, so the byte is captured at that edge.
  - Next state START; baud counter cleared to 0.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`; counts 0 … `CLKS_PER_BIT`-1.
  - Terminal count (`tc`) when the count equals `CLKS_PER_BIT`-1; counter wraps to 0 at `tc`.
  - Every non-IDLE state lasts exactly `CLKS_PER_BIT` cycles.
- START: `tx_out` = 0. On `tc`: go to DATA, bit index cleared to 0.
- DATA:
  - `tx_out` = shift register bit 0.
  - On `tc`: shift strobe pulses for one cycle and the bit index increments.
  - After index 7 (`tc` with index = 7): go to PARITY, or to STOP if parity is compiled out.
  - Exactly 7 shift pulses are needed; an 8th is harmless because the register zero-fills.
- PARITY: `tx_out` = parity register. On `tc`: go to STOP.
- STOP:
  - `tx_out` = 1.
  - On `tc`: `tx_done` = 1 for that cycle and the next state is IDLE.
- `tx_start` while busy: ignored, not queued. `tx_data_in` changes while busy have no effect.
- Load and shift strobes are never asserted in the same cycle.
- Reset, including mid-frame, forces asynchronously:
  - state IDLE, counters 0, shift register 0, parity register 0;
  - `tx_out` = 1, `tx_busy` = 0, `tx_done` = 0.

## Timing
- Acceptance edge T: START is visible from T+1, with `tx_out` = 0 and `tx_busy` = 1.
- Frame length: 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- `tx_done` is high in cycle T + frame length.
- Back-to-back frames:
  - `tx_start` may be asserted in the cycle `tx_done` is high, but it is not accepted then (state is still STOP).
  - The earliest acceptance is the following IDLE cycle, so there is a minimum of one idle-high cycle between stop bit and next start bit.
- `tx_out` is decoded combinationally from registered state, the registered shift-register bit 0 and the registered parity bit. No input-to-`tx_out` combinational path exists.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - PARITY state is present.
  - Even parity (XOR of `tx_data_in`) is registered at acceptance.
  - Frame is 11 bit times.
- Undefined:
  - No PARITY state and no parity register.
  - DATA goes directly to STOP; frame is 10 bit times.

## Structure
- Shared package `uart_pkg`:
  - state encoding typedef (IDLE = 0, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS` = 8.
- One sub-module: the existing `Tx_PISO` shift register, instantiated with:
  - `Load_data` from the load strobe, `shift` from the shift strobe;
  - `piso_reset` tied to `tx_reset`, `clk` shared;
  - its `Data_out` feeding the `tx_out` mux.
- Controller logic (FSM, baud counter, bit index, parity, output mux) lives in `uart_tx_ctrl`.

## Test plan
Bench uses `CLKS_PER_BIT` = 4.
- Reset then idle 20 cycles: `tx_out` = 1, `tx_busy` = 0, `tx_done` never pulses.
- `tx_start` with 0xA5, parity off:
  - `tx_out` = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles;
  - `tx_done` at T+40.
- 0x07 with `UART_TX_PARITY_EN`: parity bit = 1 after the data bits; `tx_done` at T+44. Repeat with 0xA5: parity bit = 0.
- `tx_start` pulsed with 0xFF in the middle of a 0x00 frame: the 0x00 frame completes unchanged and no second frame is sent.
- `tx_start` held high continuously with 0x3C: frames repeat, separated by exactly one idle-high cycle after each `tx_done`.
- `tx_reset` asserted during DATA bit 3:
  - `tx_out` = 1 and `tx_busy` = 0 immediately;
  - after release, a new 0x55 frame transmits correctly.
